// File: rtl/axi_sram_bridge.sv
// AXI slave terminating the core's external bus onto one single-port synchronous SRAM.
// Serves one INCR burst (1-16 words) at a time, alternating read/write grants on contention.
module axi_sram_bridge #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-3:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-3:0]   addr;
  logic [3:0]              len, id, ret_cnt;
  logic [4:0]              cnt;
  logic                    last_grant_wr, fresh, rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_hold;
  logic                    grant_rd, grant_wr, rd_issue, w_beat, w_final, r_hs;
  logic                    unused;

  assign unused  = ^{WID, AWADDR[1:0], ARADDR[1:0]};
  assign w_final = (cnt[3:0] == len);
  assign r_hs    = rvalid_q && RREADY;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    rd_issue   = 1'b0;
    w_beat     = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so the ready outputs read 0 while reset is held.
        if (!rst) begin
          grant_rd = ARVALID && (!AWVALID || last_grant_wr);
          grant_wr = AWVALID && !grant_rd;
        end
        if (grant_rd)      state_next = RD;
        else if (grant_wr) state_next = WR;
      end
      RD: begin
        rd_issue = (cnt <= {1'b0, len}) && (!rvalid_q || RREADY);
        if (r_hs && RLAST) state_next = IDLE;
      end
      WR: begin
        WREADY = 1'b1;
        w_beat = WVALID;
        if (w_beat && w_final) state_next = WRESP;
      end
      WRESP: begin
        BVALID = 1'b1;
        if (BREADY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ARREADY    = grant_rd;
  assign AWREADY    = grant_wr;
  assign sram_en    = rd_issue || w_beat;
  assign sram_we    = w_beat;
  assign sram_addr  = addr;
  assign sram_wdata = WDATA;
  assign RVALID     = rvalid_q;
  assign RLAST      = rvalid_q && (ret_cnt == len);
  assign RID        = id;
  assign BID        = id;
  // Fresh SRAM data passes straight through; a stalled beat is replayed from the hold register.
  assign RDATA      = fresh ? sram_rdata : rdata_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: sequential state uses non-blocking assignments only, so reads see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      len           <= '0;
      id            <= '0;
      cnt           <= '0;
      ret_cnt       <= '0;
      last_grant_wr <= 1'b1;
      fresh         <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_hold    <= '0;
      protocol_err  <= 1'b0;
    end else begin
      fresh      <= rd_issue;
      rvalid_q   <= rd_issue || (rvalid_q && !RREADY);
      rdata_hold <= RDATA;
      if (grant_rd || grant_wr) begin
        addr          <= grant_rd ? ARADDR[ADDR_WIDTH-1:2] : AWADDR[ADDR_WIDTH-1:2];
        len           <= grant_rd ? ARLEN : AWLEN;
        id            <= grant_rd ? ARID : AWID;
        cnt           <= '0;
        ret_cnt       <= '0;
        last_grant_wr <= grant_wr;
      end
      if (rd_issue || w_beat) begin
        addr <= addr + 1'b1;
        cnt  <= cnt + 5'd1;
      end
      if (r_hs) ret_cnt <= ret_cnt + 4'd1;
      if (w_beat && (WLAST != w_final)) protocol_err <= 1'b1;
    end
  end

endmodule
